vfd_rate_meter: RTL

//  Event-rate meter in the prescaled clock domain. Counts rising edges of an

---
 rtl/vfd_rate_meter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vfd_rate_meter.sv
// Event-rate meter: counts synchronised rising edges of i_event over a gate
// window of GATE_CYCLES clocks and presents each count through a valid/ack register.
module vfd_rate_meter #(
  parameter int unsigned GATE_CYCLES = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             w_clkout,
  input  logic             rst_tb,
  input  logic             i_enable,
  input  logic             i_event,
  input  logic             i_ack,
  output logic [CNT_W-1:0] o_count,
  output logic             o_valid,
  output logic             o_ovf,
  output logic             o_lost,
  output logic             o_busy
);

  localparam int unsigned      GATE_W    = $clog2(GATE_CYCLES + 1);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q;
  logic              prev_q;
  logic [GATE_W-1:0] gate_q, gate_d;
  logic [CNT_W-1:0]  evt_q, evt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  count_d;
  logic              valid_d, res_ovf_d, lost_d, busy_d;

  logic              evt_rise_c;
  logic              evt_sat_c;
  logic [CNT_W-1:0]  evt_next_c;
  logic              ovf_next_c;
  logic              result_ld_c;

  // Two-flop synchroniser plus edge flop; runs in every state
  always_ff @(posedge w_clkout or negedge rst_tb) begin
    if (!rst_tb) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_event};
      prev_q <= sync_q[1];
    end
  end

  // State, window counters and result register
  always_ff @(posedge w_clkout or negedge rst_tb) begin
    if (!rst_tb) begin
      state_q <= IDLE;
      gate_q  <= '0;
      evt_q   <= '0;
      ovf_q   <= 1'b0;
      o_count <= '0;
      o_valid <= 1'b0;
      o_ovf   <= 1'b0;
      o_lost  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
      o_count <= count_d;
      o_valid <= valid_d;
      o_ovf   <= res_ovf_d;
      o_lost  <= lost_d;
      o_busy  <= busy_d;
    end
  end

  // Count including this cycle's edge; the last gate cycle's edge still lands
  always_comb begin
    evt_rise_c = sync_q[1] & ~prev_q;
    evt_sat_c  = (evt_q == CNT_MAX);
    evt_next_c = evt_q;
    if (evt_rise_c && !evt_sat_c) begin
      evt_next_c = evt_q + 1'b1;
    end
    ovf_next_c = ovf_q | (evt_rise_c & evt_sat_c);
  end

  // Next-state, window sequencing and result handshake
  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    evt_d       = evt_q;
    ovf_d       = ovf_q;
    result_ld_c = 1'b0;
    count_d     = o_count;
    valid_d     = o_valid;
    res_ovf_d   = o_ovf;
    lost_d      = o_lost;

    case (state_q)
      IDLE: begin
        if (i_enable) begin
          state_d = GATE;
          gate_d  = GATE_LOAD;
          evt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      GATE: begin
        if (gate_q == '0) begin
          // Window complete; back-to-back restart has no dead cycle
          result_ld_c = 1'b1;
          gate_d      = GATE_LOAD;
          evt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = i_enable ? GATE : IDLE;
        end else if (!i_enable) begin
          state_d = IDLE;
        end else begin
          gate_d = gate_q - 1'b1;
          evt_d  = evt_next_c;
          ovf_d  = ovf_next_c;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (result_ld_c) begin
      count_d   = evt_next_c;
      res_ovf_d = ovf_next_c;
      valid_d   = 1'b1;
      if (o_valid && !i_ack) begin
        lost_d = 1'b1;
      end
    end else if (o_valid && i_ack) begin
      valid_d = 1'b0;
      lost_d  = 1'b0;
    end

    busy_d = (state_d == GATE);
  end

endmodule
